sim_reset_sequencer: RTL and testbench

SIM_RESET_SEQUENCER -- requirements
Module: sim_reset_sequencer

---
 rtl/sim_ctrl_pkg.sv | 17 +
 rtl/clk_divider.sv | 37 +++
 rtl/sim_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_sim_reset_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// rtl/sim_ctrl_pkg.sv - shared types and constants for the reset sequencer
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int RUN_CYCLES_W = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - free-running registered clock divider, toggles every DIV/2 cycles
module clk_divider #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic nRST,
    output logic clk_out
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(HALF) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        clk_d = clk_q;
        if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/sim_reset_sequencer.sv
// rtl/sim_reset_sequencer.sv - staged reset release, bounded run window and derived clock
import sim_ctrl_pkg::*;

module sim_reset_sequencer #(
    parameter int NUM_RESETS  = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 4,
    parameter int DIV         = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    soft_reset,
    input  logic                    stop,
    output logic [NUM_RESETS-1:0]   nRST_stage,
    output logic                    CLK_derivedClock,
    output logic                    started,
    output logic                    running,
    output logic                    done,
    output logic [RUN_CYCLES_W-1:0] run_cycles
);

    localparam int CNT_MAX = max_int(max_int(HOLD_CYCLES, STAGE_GAP), DIV / 2);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_RESETS-1:0]   stage_q, stage_d, next_stage;
    logic                    started_q, started_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic [RUN_CYCLES_W-1:0] run_q, run_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        started_d  = 1'b0;
        running_d  = running_q;
        done_d     = done_q;
        run_d      = run_q;
        // Released bits are kept by OR-ing, so release order is strictly ascending.
        next_stage = (stage_q << 1) | NUM_RESETS'(1);

        if (soft_reset) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            stage_d   = '0;
            running_d = 1'b0;
            done_d    = 1'b0;
            run_d     = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_d      = '0;
                        stage_d[0] = 1'b1;
                        if (NUM_RESETS == 1) begin
                            state_d   = ST_RUN;
                            started_d = 1'b1;
                            running_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_d   = '0;
                        stage_d = next_stage;
                        if (&next_stage) begin
                            state_d   = ST_RUN;
                            started_d = 1'b1;
                            running_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d   = ST_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        if (run_q != '1) begin
                            run_d = run_q + 1'b1;
                        end
                        if (run_d >= RUN_CYCLES_W'(TIMEOUT)) begin
                            state_d   = ST_DONE;
                            running_d = 1'b0;
                            done_d    = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            stage_q   <= '0;
            started_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            started_q <= started_d;
            running_q <= running_d;
            done_q    <= done_d;
            run_q     <= run_d;
        end
    end

    clk_divider #(
        .DIV(DIV)
    ) u_clk_divider (
        .CLK    (CLK),
        .nRST   (nRST),
        .clk_out(CLK_derivedClock)
    );

    assign nRST_stage = stage_q;
    assign started    = started_q;
    assign running    = running_q;
    assign done       = done_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_sim_reset_sequencer.sv
// tb/tb_sim_reset_sequencer.sv - directed self-checking bench for sim_reset_sequencer
module tb_sim_reset_sequencer;

    logic        clk;
    logic        n_rst;
    logic        a_soft, a_stop, b_soft, b_stop;
    logic [1:0]  a_stage;
    logic [0:0]  b_stage;
    logic        a_clkd, a_started, a_running, a_done;
    logic        b_clkd, b_started, b_running, b_done;
    logic [31:0] a_run, b_run;
    int          checks = 0;
    int          errors = 0;

    sim_reset_sequencer #(
        .NUM_RESETS(2), .HOLD_CYCLES(10), .STAGE_GAP(4), .DIV(4), .TIMEOUT(5)
    ) u_a (
        .CLK(clk), .nRST(n_rst), .soft_reset(a_soft), .stop(a_stop),
        .nRST_stage(a_stage), .CLK_derivedClock(a_clkd), .started(a_started),
        .running(a_running), .done(a_done), .run_cycles(a_run)
    );

    sim_reset_sequencer #(
        .NUM_RESETS(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .DIV(2), .TIMEOUT(3)
    ) u_b (
        .CLK(clk), .nRST(n_rst), .soft_reset(b_soft), .stop(b_stop),
        .nRST_stage(b_stage), .CLK_derivedClock(b_clkd), .started(b_started),
        .running(b_running), .done(b_done), .run_cycles(b_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0; a_soft = 1'b0; a_stop = 1'b0; b_soft = 1'b0; b_stop = 1'b0;
        step(2);
        check("rst_a_stage", a_stage, 0);
        check("rst_a_clkd", a_clkd, 0);
        check("rst_a_flags", {a_started, a_running, a_done}, 0);
        check("rst_a_run", a_run, 0);
        check("rst_b_stage", b_stage, 0);
        check("rst_b_clkd", b_clkd, 0);

        n_rst = 1'b1;
        step(1);                                   // edge 1
        check("e1_a_clkd", a_clkd, 0);
        check("e1_b_clkd", b_clkd, 1);
        check("e1_b_stage", b_stage, 1);
        check("e1_b_started", b_started, 1);
        check("e1_b_running", b_running, 1);
        a_stop = 1'b1;                             // stop during HOLD is ignored
        step(1);                                   // edge 2
        a_stop = 1'b0;
        check("e2_a_clkd", a_clkd, 1);
        check("e2_b_clkd", b_clkd, 0);
        check("e2_b_started", b_started, 0);
        check("e2_a_stage", a_stage, 0);
        check("e2_a_done", a_done, 0);
        step(7);                                   // edge 9
        check("e9_a_stage", a_stage, 0);
        check("e9_b_done", b_done, 1);
        check("e9_b_run", b_run, 3);
        check("e9_b_running", b_running, 0);
        check("e9_b_stage", b_stage, 1);
        step(1);                                   // edge 10
        check("e10_a_stage", a_stage, 2'b01);
        check("e10_a_running", a_running, 0);
        step(3);                                   // edge 13
        check("e13_a_stage", a_stage, 2'b01);
        check("e13_a_started", a_started, 0);
        step(1);                                   // edge 14
        check("e14_a_stage", a_stage, 2'b11);
        check("e14_a_started", a_started, 1);
        check("e14_a_running", a_running, 1);
        check("e14_a_run", a_run, 0);
        step(1);                                   // edge 15
        check("e15_a_started", a_started, 0);
        check("e15_a_run", a_run, 1);
        step(3);                                   // edge 18
        check("e18_a_done", a_done, 0);
        step(1);                                   // edge 19
        check("e19_a_done", a_done, 1);
        check("e19_a_running", a_running, 0);
        check("e19_a_run", a_run, 5);
        step(3);                                   // edge 22
        check("e22_a_run", a_run, 5);
        check("e22_a_done", a_done, 1);
        check("e22_a_stage", a_stage, 2'b11);

        a_soft = 1'b1;                             // soft reset out of DONE
        step(1);                                   // edge 23
        a_soft = 1'b0;
        check("e23_a_stage", a_stage, 0);
        check("e23_a_done", a_done, 0);
        check("e23_a_run", a_run, 0);
        step(10);                                  // edge 33
        check("e33_a_stage", a_stage, 2'b01);
        step(2);                                   // edge 35
        a_soft = 1'b1;                             // soft reset during RELEASE
        step(1);                                   // edge 36
        a_soft = 1'b0;
        check("e36_a_stage", a_stage, 0);
        check("e36_a_clkd", a_clkd, 0);
        step(2);                                   // edge 38
        check("e38_a_clkd", a_clkd, 1);
        step(7);                                   // edge 45
        check("e45_a_stage", a_stage, 0);
        step(1);                                   // edge 46
        check("e46_a_stage", a_stage, 2'b01);
        step(4);                                   // edge 50
        check("e50_a_stage", a_stage, 2'b11);
        check("e50_a_started", a_started, 1);
        step(3);                                   // edge 53
        check("e53_a_run", a_run, 3);
        a_stop = 1'b1;
        step(1);                                   // edge 54
        a_stop = 1'b0;
        check("e54_a_done", a_done, 1);
        check("e54_a_running", a_running, 0);
        check("e54_a_run", a_run, 3);

        a_soft = 1'b1;
        step(1);                                   // edge 55
        a_soft = 1'b0;
        step(15);                                  // edge 70
        check("e70_a_running", a_running, 1);
        check("e70_a_run", a_run, 1);
        a_soft = 1'b1;                             // soft reset beats stop
        a_stop = 1'b1;
        step(1);                                   // edge 71
        a_soft = 1'b0;
        a_stop = 1'b0;
        check("e71_a_stage", a_stage, 0);
        check("e71_a_flags", {a_running, a_done}, 0);
        check("e71_a_run", a_run, 0);
        step(16);                                  // edge 87
        check("e87_a_running", a_running, 1);
        check("e87_a_run", a_run, 2);

        #2;
        n_rst = 1'b0;                              // asynchronous, between edges
        #1;
        check("arst_a_stage", a_stage, 0);
        check("arst_a_flags", {a_started, a_running, a_done}, 0);
        check("arst_a_run", a_run, 0);
        check("arst_a_clkd", a_clkd, 0);
        check("arst_b_stage", b_stage, 0);
        check("arst_b_flags", {b_clkd, b_started, b_running, b_done}, 0);
        check("arst_b_run", b_run, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
